// File: rtl/eth_rx_demux.sv
// Ethernet RX demultiplexer: parses Ethernet/IPv4/UDP headers and steers whole
// frames to the TLP, command or config stream through a fixed delay line.
module eth_rx_demux #(
  parameter int unsigned DEPTH         = 5,
  parameter logic [15:0] TLP_PORT_BASE = 16'h3000,
  parameter logic [15:0] TLP_PORT_MASK = 16'hFFF0,
  parameter logic [15:0] CMD_PORT      = 16'h2FFF,
  parameter logic [15:0] CFG_PORT      = 16'h2FFE,
  parameter int unsigned DFIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        eth_rx_tvalid,
  input  logic [63:0] eth_rx_tdata,
  input  logic [7:0]  eth_rx_tkeep,
  input  logic        eth_rx_tlast,
  input  logic        eth_rx_tuser,

  input  logic [31:0] adapter_reg_srcip,

  output logic        m_tlp_tvalid,
  output logic [63:0] m_tlp_tdata,
  output logic [7:0]  m_tlp_tkeep,
  output logic        m_tlp_tlast,
  output logic        m_tlp_tuser,

  output logic        m_cmd_tvalid,
  output logic [63:0] m_cmd_tdata,
  output logic [7:0]  m_cmd_tkeep,
  output logic        m_cmd_tlast,
  output logic        m_cmd_tuser,

  output logic        m_cfg_tvalid,
  output logic [63:0] m_cfg_tdata,
  output logic [7:0]  m_cfg_tkeep,
  output logic        m_cfg_tlast,
  output logic        m_cfg_tuser,

  output logic [31:0] rx_frame_cnt,
  output logic [31:0] rx_drop_cnt
);

  // The output register is the last delay stage, so DEPTH-1 stages precede it.
  localparam int unsigned NSTG  = DEPTH - 1;
  localparam int unsigned PTR_W = (DFIFO_DEPTH > 1) ? $clog2(DFIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DFIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_SYNC, S_HDR, S_BODY} state_t;
  typedef enum logic [1:0] {D_DROP, D_TLP, D_CMD, D_CFG} dest_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
    logic        sof;
  } stage_t;

  state_t            state;
  logic [2:0]        beat_idx;
  logic              eth_ok;
  logic              proto_ok;
  logic [15:0]       ip_hi;

  stage_t            pipe [NSTG];
  stage_t            in_stage;
  stage_t            ex;

  dest_t             fifo_mem [DFIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              do_push;
  logic              do_pop;
  dest_t             push_val;
  dest_t             pop_val;
  dest_t             route;
  logic [15:0]       udp_port;
  logic [31:0]       dst_ip;

  dest_t             cur_dest;
  logic              cur_valid;
  logic              eff_valid;
  dest_t             eff_dest;

  logic              tlp_valid;
  logic              cmd_valid;
  logic              cfg_valid;
  logic [63:0]       out_data;
  logic [7:0]        out_keep;
  logic              out_last;
  logic              out_user;
  logic [31:0]       frame_cnt;
  logic [31:0]       drop_cnt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DFIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Routing decision for the frame whose beat 4 is on the input this cycle.
  always_comb begin
    udp_port = {eth_rx_tdata[39:32], eth_rx_tdata[47:40]};
    dst_ip   = {ip_hi, eth_rx_tdata[7:0], eth_rx_tdata[15:8]};
    route    = D_DROP;
    if (eth_ok && proto_ok && (dst_ip == adapter_reg_srcip)) begin
      if (udp_port == CMD_PORT)
        route = D_CMD;
      else if (udp_port == CFG_PORT)
        route = D_CFG;
      else if ((udp_port & TLP_PORT_MASK) == TLP_PORT_BASE)
        route = D_TLP;
    end
    push     = eth_rx_tvalid && (state == S_HDR) && ((beat_idx == 3'd4) || eth_rx_tlast);
    push_val = (beat_idx == 3'd4) ? route : D_DROP;
  end

  always_comb begin
    in_stage.valid = eth_rx_tvalid;
    in_stage.data  = eth_rx_tdata;
    in_stage.keep  = eth_rx_tkeep;
    in_stage.last  = eth_rx_tlast;
    in_stage.user  = eth_rx_tuser;
    in_stage.sof   = eth_rx_tvalid && (state == S_HDR) && (beat_idx == 3'd0);
  end

  // Beat 0 of a frame exits in the same cycle beat 4 arrives, so an empty FIFO
  // hands the incoming decision straight through.
  always_comb begin
    ex         = pipe[NSTG-1];
    fifo_empty = (fifo_cnt == '0);
    pop        = ex.valid && ex.sof;
    pop_val    = fifo_empty ? push_val : fifo_mem[rd_ptr];
    do_push    = push && !(pop && fifo_empty);
    do_pop     = pop && !fifo_empty;
    eff_valid  = ex.valid && (ex.sof || cur_valid);
    eff_dest   = ex.sof ? pop_val : cur_dest;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_SYNC;
      beat_idx <= 3'd0;
      eth_ok   <= 1'b0;
      proto_ok <= 1'b0;
      ip_hi    <= 16'h0000;
    end else if (eth_rx_tvalid) begin
      case (state)
        S_SYNC: begin
          if (eth_rx_tlast) state <= S_HDR;
          beat_idx <= 3'd0;
        end
        S_HDR: begin
          case (beat_idx)
            3'd1: eth_ok   <= ({eth_rx_tdata[39:32], eth_rx_tdata[47:40]} == 16'h0800) &&
                              (eth_rx_tdata[55:48] == 8'h45);
            3'd2: proto_ok <= (eth_rx_tdata[63:56] == 8'h11);
            3'd3: ip_hi    <= {eth_rx_tdata[55:48], eth_rx_tdata[63:56]};
            default: ;
          endcase
          if (beat_idx == 3'd4) begin
            state    <= eth_rx_tlast ? S_HDR : S_BODY;
            beat_idx <= 3'd0;
          end else if (eth_rx_tlast) begin
            beat_idx <= 3'd0;
          end else begin
            beat_idx <= beat_idx + 3'd1;
          end
        end
        S_BODY: begin
          if (eth_rx_tlast) state <= S_HDR;
          beat_idx <= 3'd0;
        end
        default: state <= S_SYNC;
      endcase
    end else if (state == S_SYNC) begin
      // tvalid never drops inside a frame, so an idle cycle is a frame boundary.
      state <= S_HDR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NSTG; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= in_stage;
      for (int unsigned i = 1; i < NSTG; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= push_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && (fifo_cnt == CNT_W'(DFIFO_DEPTH))))
        else $fatal(1, "eth_rx_demux: decision FIFO overflow");
      assert (!(pop && fifo_empty && !push))
        else $fatal(1, "eth_rx_demux: decision FIFO underflow");
    end
  end

  // Output stage: steer the exiting beat and track the current frame's route.
  always_ff @(posedge clk) begin
    if (rst) begin
      tlp_valid <= 1'b0;
      cmd_valid <= 1'b0;
      cfg_valid <= 1'b0;
      out_last  <= 1'b0;
      out_user  <= 1'b0;
      cur_valid <= 1'b0;
      cur_dest  <= D_DROP;
      frame_cnt <= 32'd0;
      drop_cnt  <= 32'd0;
    end else begin
      tlp_valid <= eff_valid && (eff_dest == D_TLP);
      cmd_valid <= eff_valid && (eff_dest == D_CMD);
      cfg_valid <= eff_valid && (eff_dest == D_CFG);
      out_last  <= ex.last;
      out_user  <= ex.user;
      if (ex.valid) begin
        if (ex.sof) begin
          cur_dest  <= pop_val;
          cur_valid <= !ex.last;
          if (pop_val == D_DROP) drop_cnt  <= drop_cnt + 32'd1;
          else                   frame_cnt <= frame_cnt + 32'd1;
        end else if (ex.last) begin
          cur_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    out_data <= ex.data;
    out_keep <= ex.keep;
  end

  assign m_tlp_tvalid = tlp_valid;
  assign m_tlp_tdata  = out_data;
  assign m_tlp_tkeep  = out_keep;
  assign m_tlp_tlast  = out_last;
  assign m_tlp_tuser  = out_user;

  assign m_cmd_tvalid = cmd_valid;
  assign m_cmd_tdata  = out_data;
  assign m_cmd_tkeep  = out_keep;
  assign m_cmd_tlast  = out_last;
  assign m_cmd_tuser  = out_user;

  assign m_cfg_tvalid = cfg_valid;
  assign m_cfg_tdata  = out_data;
  assign m_cfg_tkeep  = out_keep;
  assign m_cfg_tlast  = out_last;
  assign m_cfg_tuser  = out_user;

  assign rx_frame_cnt = frame_cnt;
  assign rx_drop_cnt  = drop_cnt;

endmodule

// File: tb/tb_eth_rx_demux.sv
// Scoreboard bench for eth_rx_demux: frames are built as byte arrays, routed by a
// byte-level model, and every forwarded beat is checked for content and latency.
module tb_eth_rx_demux;

  localparam int unsigned DEPTH = 5;
  localparam logic [31:0] MY_IP = 32'h0A000001;

  logic        clk = 1'b0;
  logic        rst;
  logic        eth_rx_tvalid;
  logic [63:0] eth_rx_tdata;
  logic [7:0]  eth_rx_tkeep;
  logic        eth_rx_tlast;
  logic        eth_rx_tuser;
  logic [31:0] adapter_reg_srcip;
  logic        m_tlp_tvalid, m_tlp_tlast, m_tlp_tuser;
  logic [63:0] m_tlp_tdata;
  logic [7:0]  m_tlp_tkeep;
  logic        m_cmd_tvalid, m_cmd_tlast, m_cmd_tuser;
  logic [63:0] m_cmd_tdata;
  logic [7:0]  m_cmd_tkeep;
  logic        m_cfg_tvalid, m_cfg_tlast, m_cfg_tuser;
  logic [63:0] m_cfg_tdata;
  logic [7:0]  m_cfg_tkeep;
  logic [31:0] rx_frame_cnt;
  logic [31:0] rx_drop_cnt;

  eth_rx_demux dut (
    .clk(clk), .rst(rst),
    .eth_rx_tvalid(eth_rx_tvalid), .eth_rx_tdata(eth_rx_tdata), .eth_rx_tkeep(eth_rx_tkeep),
    .eth_rx_tlast(eth_rx_tlast), .eth_rx_tuser(eth_rx_tuser),
    .adapter_reg_srcip(adapter_reg_srcip),
    .m_tlp_tvalid(m_tlp_tvalid), .m_tlp_tdata(m_tlp_tdata), .m_tlp_tkeep(m_tlp_tkeep),
    .m_tlp_tlast(m_tlp_tlast), .m_tlp_tuser(m_tlp_tuser),
    .m_cmd_tvalid(m_cmd_tvalid), .m_cmd_tdata(m_cmd_tdata), .m_cmd_tkeep(m_cmd_tkeep),
    .m_cmd_tlast(m_cmd_tlast), .m_cmd_tuser(m_cmd_tuser),
    .m_cfg_tvalid(m_cfg_tvalid), .m_cfg_tdata(m_cfg_tdata), .m_cfg_tkeep(m_cfg_tkeep),
    .m_cfg_tlast(m_cfg_tlast), .m_cfg_tuser(m_cfg_tuser),
    .rx_frame_cnt(rx_frame_cnt), .rx_drop_cnt(rx_drop_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
    int unsigned cyc;
  } exp_t;

  exp_t        q_tlp[$];
  exp_t        q_cmd[$];
  exp_t        q_cfg[$];
  int          n_checks = 0;
  int          n_fails  = 0;
  int unsigned mdl_frames = 0;
  int unsigned mdl_drops  = 0;
  logic [7:0]  fr[$];
  logic        mon_en = 1'b0;

  task automatic put(input int idx, input logic [7:0] v);
    if (idx < fr.size()) fr[idx] = v;
  endtask

  // Frame of nbeats beats; frames longer than the header may end on a partial beat.
  task automatic build(input logic [15:0] etype, input logic [7:0] verihl, input logic [7:0] proto,
                       input logic [31:0] dip, input logic [15:0] port, input int nbeats);
    int nbytes;
    nbytes = nbeats * 8 - ((nbeats > 5) ? int'($urandom_range(0, 7)) : 0);
    fr.delete();
    for (int i = 0; i < nbytes; i++) fr.push_back(8'($urandom));
    put(12, etype[15:8]); put(13, etype[7:0]);
    put(14, verihl);
    put(23, proto);
    put(30, dip[31:24]); put(31, dip[23:16]); put(32, dip[15:8]); put(33, dip[7:0]);
    put(36, port[15:8]); put(37, port[7:0]);
  endtask

  // 0 drop, 1 tlp, 2 cmd, 3 cfg
  function automatic int model_route();
    logic [15:0] port;
    if (fr.size() < 40) return 0;
    if ({fr[12], fr[13]} != 16'h0800) return 0;
    if (fr[14] != 8'h45) return 0;
    if (fr[23] != 8'h11) return 0;
    if ({fr[30], fr[31], fr[32], fr[33]} != MY_IP) return 0;
    port = {fr[36], fr[37]};
    if (port == 16'h2FFF) return 2;
    if (port == 16'h2FFE) return 3;
    if (port >= 16'h3000 && port <= 16'h300F) return 1;
    return 0;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      eth_rx_tvalid = 1'b0;
      eth_rx_tlast  = 1'b0;
      eth_rx_tuser  = 1'b0;
      rst           = 1'b0;
    end
  endtask

  // Drive fr as one frame; rst_beat >= 0 pulses reset together with that beat.
  task automatic send(input int rst_beat, input int gap);
    int   nb;
    int   dest;
    logic usr;
    exp_t e;
    nb   = (fr.size() + 7) / 8;
    dest = model_route();
    usr  = ($urandom_range(0, 3) == 0);
    for (int k = 0; k < nb; k++) begin
      logic [63:0] d;
      logic [7:0]  kp;
      d  = '0;
      kp = '0;
      for (int j = 0; j < 8; j++) begin
        if (k * 8 + j < fr.size()) begin
          d[8*j +: 8] = fr[k * 8 + j];
          kp[j]       = 1'b1;
        end
      end
      @(negedge clk);
      eth_rx_tvalid = 1'b1;
      eth_rx_tdata  = d;
      eth_rx_tkeep  = kp;
      eth_rx_tlast  = (k == nb - 1);
      eth_rx_tuser  = (k == nb - 1) ? usr : 1'b0;
      rst           = (k == rst_beat);
      if (rst_beat < 0 && dest != 0) begin
        e.data = d; e.keep = kp; e.last = (k == nb - 1);
        e.user = (k == nb - 1) ? usr : 1'b0;
        e.cyc  = cyc + DEPTH;
        case (dest)
          1: q_tlp.push_back(e);
          2: q_cmd.push_back(e);
          default: q_cfg.push_back(e);
        endcase
      end
    end
    if (rst_beat >= 0) begin
      mdl_frames = 0;
      mdl_drops  = 0;
    end else if (dest == 0) begin
      mdl_drops++;
    end else begin
      mdl_frames++;
    end
    if (gap > 0) idle(gap);
  endtask

  task automatic check_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk(input int id, input string nm, input logic v, input logic [63:0] d,
                     input logic [7:0] k, input logic l, input logic u);
    exp_t e;
    bit   have;
    if (v !== 1'b1) return;
    have = 1'b0;
    case (id)
      1: if (q_tlp.size() > 0) begin e = q_tlp.pop_front(); have = 1'b1; end
      2: if (q_cmd.size() > 0) begin e = q_cmd.pop_front(); have = 1'b1; end
      default: if (q_cfg.size() > 0) begin e = q_cfg.pop_front(); have = 1'b1; end
    endcase
    n_checks++;
    if (!have) begin
      n_fails++;
      $display("FAIL %s unexpected beat at cycle %0d: data=%h keep=%h last=%b, expected none",
               nm, cyc, d, k, l);
    end else if (d !== e.data || k !== e.keep || l !== e.last || u !== e.user || cyc != e.cyc) begin
      n_fails++;
      $display("FAIL %s beat: got data=%h keep=%h last=%b user=%b cyc=%0d, expected data=%h keep=%h last=%b user=%b cyc=%0d",
               nm, d, k, l, u, cyc, e.data, e.keep, e.last, e.user, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk(1, "tlp", m_tlp_tvalid, m_tlp_tdata, m_tlp_tkeep, m_tlp_tlast, m_tlp_tuser);
      chk(2, "cmd", m_cmd_tvalid, m_cmd_tdata, m_cmd_tkeep, m_cmd_tlast, m_cmd_tuser);
      chk(3, "cfg", m_cfg_tvalid, m_cfg_tdata, m_cfg_tkeep, m_cfg_tlast, m_cfg_tuser);
    end
  end

  task automatic check_counts(input string nm);
    check_eq({nm, " rx_frame_cnt"}, rx_frame_cnt, mdl_frames);
    check_eq({nm, " rx_drop_cnt"}, rx_drop_cnt, mdl_drops);
  endtask

  initial begin
    rst               = 1'b1;
    eth_rx_tvalid     = 1'b0;
    eth_rx_tdata      = '0;
    eth_rx_tkeep      = '0;
    eth_rx_tlast      = 1'b0;
    eth_rx_tuser      = 1'b0;
    adapter_reg_srcip = MY_IP;
    repeat (3) @(negedge clk);
    check_eq("reset tlp_tvalid", 32'(m_tlp_tvalid), 32'd0);
    check_eq("reset cmd_tvalid", 32'(m_cmd_tvalid), 32'd0);
    check_eq("reset cfg_tvalid", 32'(m_cfg_tvalid), 32'd0);
    check_eq("reset tlast", 32'(m_tlp_tlast), 32'd0);
    check_counts("reset");
    idle(3);
    mon_en = 1'b1;

    // Single TLP frame
    build(16'h0800, 8'h45, 8'h11, MY_IP, 16'h3005, 10); send(-1, 0);
    idle(12); check_counts("tlp frame");

    // Command then config frame
    build(16'h0800, 8'h45, 8'h11, MY_IP, 16'h2FFF, 10); send(-1, 2);
    build(16'h0800, 8'h45, 8'h11, MY_IP, 16'h2FFE, 10); send(-1, 0);
    idle(12); check_counts("cmd cfg");

    // Header rejections
    build(16'h0806, 8'h45, 8'h11, MY_IP, 16'h3000, 8); send(-1, 1);
    build(16'h0800, 8'h45, 8'h11, 32'h0A000002, 16'h3000, 8); send(-1, 1);
    build(16'h0800, 8'h45, 8'h11, MY_IP, 16'h1234, 8); send(-1, 0);
    idle(12); check_counts("drops");

    // Short frame followed with no gap by a TLP frame
    build(16'h0800, 8'h45, 8'h11, MY_IP, 16'h3000, 3); send(-1, 0);
    build(16'h0800, 8'h45, 8'h11, MY_IP, 16'h3000, 10); send(-1, 0);
    idle(12); check_counts("short frame");

    // Back-to-back cmd and TLP frames
    build(16'h0800, 8'h45, 8'h11, MY_IP, 16'h2FFF, 9); send(-1, 0);
    build(16'h0800, 8'h45, 8'h11, MY_IP, 16'h300F, 12); send(-1, 0);
    idle(12); check_counts("back to back");

    // Reset in the middle of a frame
    build(16'h0800, 8'h45, 8'h11, MY_IP, 16'h3001, 10); send(3, 0);
    idle(12); check_counts("mid-frame reset");
    build(16'h0800, 8'h45, 8'h11, MY_IP, 16'h3002, 10); send(-1, 0);
    idle(12); check_counts("after reset");

    // Randomized traffic
    for (int f = 0; f < 40; f++) begin
      int          r;
      logic [15:0] port;
      r = int'($urandom_range(0, 9));
      if (r < 3)       port = 16'h3000 | 16'($urandom_range(0, 15));
      else if (r == 3) port = 16'h2FFF;
      else if (r == 4) port = 16'h2FFE;
      else if (r == 5) port = 16'h3010 | 16'($urandom_range(0, 15));
      else             port = 16'($urandom);
      build(($urandom_range(0, 7) == 0) ? 16'h0806 : 16'h0800,
            ($urandom_range(0, 7) == 0) ? 8'h46 : 8'h45,
            ($urandom_range(0, 7) == 0) ? 8'h06 : 8'h11,
            ($urandom_range(0, 5) == 0) ? 32'($urandom) : MY_IP,
            port, int'($urandom_range(1, 14)));
      send(-1, int'($urandom_range(0, 2)));
    end
    idle(20); check_counts("random");

    check_eq("tlp queue drained", 32'(q_tlp.size()), 32'd0);
    check_eq("cmd queue drained", 32'(q_cmd.size()), 32'd0);
    check_eq("cfg queue drained", 32'(q_cfg.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
